// File: rtl/ro_measure_ctrl.sv
// rtl/ro_measure_ctrl.sv - ring-oscillator measurement sequencer (clear, gate, settle, capture)
//
// Parameters:
//   SETTLE_CYC  idle cycles between ro_en deassertion and the count sample (1..15)
//   CNT_W       width of the external ring-oscillator counter
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   start              measurement request, only honoured in IDLE
//   auto               sweep oscillators 0..3 when sampled with start
//   sel                oscillator for a single measurement
//   gate_len           gate window in cycles (0 means 256)
//   shift              right shift applied to the raw count
//   ro_cnt             external counter value
//   ro_sel             oscillator mux select
//   ro_en              oscillator / counter enable
//   ro_clr             one-cycle counter clear
//   busy               high whenever not IDLE
//   done               one-cycle pulse when result is updated
//   result             scaled, saturated count
//   result_sel         oscillator index belonging to result
//   ovf                last result was saturated
module ro_measure_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             auto,
    input  logic [1:0]       sel,
    input  logic [7:0]       gate_len,
    input  logic [2:0]       shift,
    input  logic [CNT_W-1:0] ro_cnt,
    output logic [1:0]       ro_sel,
    output logic             ro_en,
    output logic             ro_clr,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic [1:0]       result_sel,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_GATE    = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state, state_next;

    logic [7:0]       gate_len_q;
    logic [2:0]       shift_q;
    logic             auto_q;
    logic [1:0]       chan;
    logic [7:0]       cnt;
    logic [CNT_W-1:0] scaled;
    logic             sat;

    // chan only changes on the edge that enters CLEAR, so it doubles as the
    // mux select and naturally holds its value while idle.
    assign ro_sel = chan;
    assign ro_en  = (state == S_GATE);
    assign ro_clr = (state == S_CLEAR);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    assign scaled = ro_cnt >> shift_q;
    assign sat    = (scaled > CNT_W'(255));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = S_GATE;
            end
            S_GATE: begin
                if (cnt == 8'd0) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == 8'd0) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                if (auto_q && (chan != 2'd3)) begin
                    state_next = S_CLEAR;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_len_q <= 8'd0;
            shift_q    <= 3'd0;
            auto_q     <= 1'b0;
            chan       <= 2'd0;
            cnt        <= 8'd0;
            result     <= 8'd0;
            result_sel <= 2'd0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        gate_len_q <= gate_len;
                        shift_q    <= shift;
                        auto_q     <= auto;
                        chan       <= auto ? 2'd0 : sel;
                    end
                end
                S_CLEAR: begin
                    // gate_len of 0 wraps to 255, giving a 256-cycle window.
                    cnt <= gate_len_q - 8'd1;
                end
                S_GATE: begin
                    if (cnt == 8'd0) begin
                        cnt <= 8'(SETTLE_CYC - 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt - 8'd1;
                end
                S_CAPTURE: begin
                    result     <= sat ? 8'hFF : 8'(scaled);
                    ovf        <= sat;
                    result_sel <= chan;
                end
                S_DONE: begin
                    if (auto_q && (chan != 2'd3)) begin
                        chan <= chan + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb/tb_ro_measure_ctrl.sv - self-checking bench for ro_measure_ctrl
module tb_ro_measure_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_i = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [7:0]  gate_len = 8'd0;
    logic [2:0]  shift = 3'd0;
    logic [15:0] ro_cnt = 16'd0;
    logic [1:0]  ro_sel;
    logic        ro_en;
    logic        ro_clr;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [1:0]  result_sel;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ro_measure_ctrl #(.SETTLE_CYC(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .auto       (auto_i),
        .sel        (sel),
        .gate_len   (gate_len),
        .shift      (shift),
        .ro_cnt     (ro_cnt),
        .ro_sel     (ro_sel),
        .ro_en      (ro_en),
        .ro_clr     (ro_clr),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_sel (result_sel),
        .ovf        (ovf)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        aut;
        logic [7:0]  gl;
        logic [2:0]  sh;
        logic [15:0] cnt;
        logic [7:0]  e_res;
        logic        e_ovf;
        int          e_lat;
        int          e_en;
        logic        poke;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic run_meas(input vec_t v, input int idx);
        int cyc;
        int en_cnt;
        int clr_cnt;
        int overlap;
        int busy_low;
        int extra;
        bit seen;
        sel = v.sel; auto_i = v.aut; gate_len = v.gl; shift = v.sh;
        ro_cnt = v.cnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // parameters changed mid-measurement must not matter
        sel = ~v.sel; auto_i = ~v.aut; gate_len = v.gl + 8'd3; shift = v.sh + 3'd1;
        cyc = 1; en_cnt = 0; clr_cnt = 0; overlap = 0; busy_low = 0; seen = 1'b0;
        while (!seen && cyc < 600) begin
            if (ro_en) en_cnt++;
            if (ro_clr) clr_cnt++;
            if (ro_en && ro_clr) overlap++;
            if (!busy) busy_low++;
            if (done) begin
                seen = 1'b1;
                chk($sformatf("v%0d_latency", idx), cyc, v.e_lat);
                chk($sformatf("v%0d_result", idx), int'(result), int'(v.e_res));
                chk($sformatf("v%0d_result_sel", idx), int'(result_sel), int'(v.sel));
                chk($sformatf("v%0d_ovf", idx), int'(ovf), int'(v.e_ovf));
            end else begin
                if (v.poke && cyc == 5) start = 1'b1;
                if (v.poke && cyc == 6) start = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), int'(seen), 1);
        chk($sformatf("v%0d_en_cycles", idx), en_cnt, v.e_en);
        chk($sformatf("v%0d_clr_cycles", idx), clr_cnt, 1);
        chk($sformatf("v%0d_en_clr_overlap", idx), overlap, 0);
        chk($sformatf("v%0d_busy_drop", idx), busy_low, 0);
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_idle_quiet", idx), extra, 0);
        chk($sformatf("v%0d_ro_sel_hold", idx), int'(ro_sel), int'(v.sel));
        chk($sformatf("v%0d_result_hold", idx), int'(result), int'(v.e_res));
        auto_i = 1'b0;
    endtask

    initial begin
        int cyc;
        int n_done;
        int order_err;
        int res_err;
        int sel_err;

        //        sel   aut   gl      sh    cnt        res    ovf   lat  en   poke
        vt[0] = '{2'd2, 1'b0, 8'd10,  3'd0, 16'h0037, 8'h37, 1'b0, 17,  10,  1'b0};
        vt[1] = '{2'd1, 1'b0, 8'd3,   3'd4, 16'h1234, 8'hFF, 1'b1, 10,  3,   1'b0};
        vt[2] = '{2'd0, 1'b0, 8'd3,   3'd5, 16'h1234, 8'h91, 1'b0, 10,  3,   1'b0};
        vt[3] = '{2'd3, 1'b0, 8'd0,   3'd0, 16'h00FF, 8'hFF, 1'b0, 263, 256, 1'b1};
        vt[4] = '{2'd1, 1'b0, 8'd1,   3'd0, 16'h0100, 8'hFF, 1'b1, 8,   1,   1'b0};
        vt[5] = '{2'd0, 1'b0, 8'd255, 3'd7, 16'hFFFF, 8'hFF, 1'b1, 262, 255, 1'b0};
        vt[6] = '{2'd2, 1'b0, 8'd2,   3'd1, 16'h01FF, 8'hFF, 1'b0, 9,   2,   1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ro_en", int'(ro_en), 0);
        chk("reset_ro_clr", int'(ro_clr), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_ro_sel", int'(ro_sel), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_meas(vt[i], i);
        end

        // auto sweep: 12 cycles per channel, busy must never drop until cycle 49
        sel = 2'd3; auto_i = 1'b1; gate_len = 8'd5; shift = 3'd1;
        ro_cnt = 16'h0042; start = 1'b1;
        @(negedge clk);
        start = 1'b0; sel = 2'd1; auto_i = 1'b0; gate_len = 8'd9;
        cyc = 1; n_done = 0; order_err = 0; res_err = 0; sel_err = 0;
        while (busy && cyc < 300) begin
            if (ro_clr && (int'(ro_sel) != n_done)) sel_err++;
            if (done) begin
                if (int'(result_sel) != n_done) order_err++;
                if (result != 8'h21) res_err++;
                n_done++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("sweep_done_count", n_done, 4);
        chk("sweep_order", order_err, 0);
        chk("sweep_result", res_err, 0);
        chk("sweep_ro_sel_step", sel_err, 0);
        chk("sweep_busy_end_cycle", cyc, 49);
        chk("sweep_ro_sel_final", int'(ro_sel), 3);

        // reset during the third GATE cycle
        sel = 2'd1; auto_i = 1'b0; gate_len = 8'd20; shift = 3'd0;
        ro_cnt = 16'h0055; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midgate_ro_en", int'(ro_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ro_en", int'(ro_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_ro_sel", int'(ro_sel), 0);
        rst_n = 1'b1;
        run_meas(vt[0], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=1 expected=0");
        $fatal(1);
    end

endmodule
